// File: rtl/bist_round_controller_if.sv
// Control/status bundle between the test-control register block and the BIST round sequencer.
interface bist_round_controller_if #(
    parameter int unsigned RND_W = 2
);
    logic             start;
    logic             abort;
    logic             init;
    logic             running;
    logic             toggle;
    logic             finish;
    logic             bist_end;
    logic             aborted;
    logic [RND_W-1:0] round;

    modport master (
        output start, abort,
        input  init, running, toggle, finish, bist_end, aborted, round
    );

    modport slave (
        input  start, abort,
        output init, running, toggle, finish, bist_end, aborted, round
    );
endinterface

// File: rtl/bist_round_controller.sv
// BIST sequencer: NROUNDS rounds of NCLOCK running cycles, a toggle pulse after each round,
// with abort, sticky status flags and an optional free-running mode.
module bist_round_controller #(
    parameter int unsigned NCLOCK     = 650,
    parameter int unsigned NROUNDS    = 4,
    parameter bit          CONTINUOUS = 1'b0
) (
    input logic                    clk,
    input logic                    reset,
    bist_round_controller_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(NCLOCK);
    localparam int unsigned RND_W = (NROUNDS > 1) ? $clog2(NROUNDS) : 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(NCLOCK - 1);
    localparam logic [RND_W-1:0] RndLast = RND_W'(NROUNDS - 1);

    typedef enum logic [2:0] {StIdle, StInit, StRun, StToggle, StFinish} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RND_W-1:0] round_q, round_d;
    logic             bist_end_q, bist_end_d;
    logic             aborted_q, aborted_d;
    logic             start_q;
    logic             start_edge;

    assign start_edge = bus.start & ~start_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        round_d    = round_q;
        bist_end_d = bist_end_q;
        aborted_d  = aborted_q;
        unique case (state_q)
            StIdle: begin
                if (start_edge && !bus.abort) begin
                    state_d    = StInit;
                    cnt_d      = '0;
                    round_d    = '0;
                    bist_end_d = 1'b0;
                    aborted_d  = 1'b0;
                end
            end
            StInit: begin
                if (bus.abort) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StToggle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StToggle: begin
                if (bus.abort) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else if (round_q == RndLast) begin
                    state_d = StFinish;
                end else begin
                    state_d = StRun;
                    round_d = round_q + RND_W'(1);
                end
            end
            StFinish: begin
                // Free-running mode only flashes bist_end during FINISH, never latches it.
                if (CONTINUOUS) begin
                    state_d = StInit;
                    cnt_d   = '0;
                    round_d = '0;
                end else begin
                    state_d    = StIdle;
                    bist_end_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            round_q    <= '0;
            bist_end_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            round_q    <= round_d;
            bist_end_q <= bist_end_d;
            aborted_q  <= aborted_d;
        end
    end

    // Tracks start even in reset, so a start held across reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        start_q <= bus.start;
    end

    assign bus.init     = (state_q == StInit);
    assign bus.running  = (state_q == StRun);
    assign bus.toggle   = (state_q == StToggle);
    assign bus.finish   = (state_q == StFinish);
    assign bus.bist_end = bist_end_q | (state_q == StFinish);
    assign bus.aborted  = aborted_q;
    assign bus.round    = round_q;
endmodule

// File: tb/tb_bist_round_controller.sv
// Directed bench: one-shot controller (8 cycles x 3 rounds) and a free-running one (4 x 2).
module tb_bist_round_controller;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_init, n_run, n_tog, n_fin;
    int   c0, f1, f2;

    bist_round_controller_if #(.RND_W(2)) bif ();
    bist_round_controller_if #(.RND_W(1)) cif ();

    bist_round_controller #(.NCLOCK(8), .NROUNDS(3), .CONTINUOUS(1'b0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    bist_round_controller #(.NCLOCK(4), .NROUNDS(2), .CONTINUOUS(1'b1)) u_dut_cont (
        .clk   (clk),
        .reset (reset),
        .bus   (cif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bif.init)    n_init++;
        if (bif.running) n_run++;
        if (bif.toggle)  n_tog++;
        if (bif.finish)  n_fin++;
    endtask

    task automatic clr();
        n_init = 0;
        n_run  = 0;
        n_tog  = 0;
        n_fin  = 0;
    endtask

    // Two-cycle start pulse; returns the cycle index in which init should be high.
    task automatic launch(output int c_init);
        bif.start = 1'b1;
        tick();
        c_init = cyc;
        check("launch_init", bif.init, 1);
        tick();
        bif.start = 1'b0;
    endtask

    task automatic wait_fin(input bit sel, input int bound, output int at);
        int k = 0;
        while (!(sel ? cif.finish : bif.finish) && k < bound) begin
            tick();
            k++;
        end
        check(sel ? "fin_cont_seen" : "fin_seen", sel ? cif.finish : bif.finish, 1);
        at = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bif.start = 1'b0;
        bif.abort = 1'b0;
        cif.start = 1'b0;
        cif.abort = 1'b0;
        clr();

        // Reset state
        tick();
        tick();
        check("rst_flags", {bif.init, bif.running, bif.toggle, bif.finish, bif.bist_end,
                            bif.aborted}, 0);
        check("rst_round", bif.round, 0);
        reset = 1'b0;
        tick();

        // Normal session: init at c0, finish 1 + 3*(8+1) = 28 cycles later
        clr();
        launch(c0);
        wait_fin(1'b0, 100, f1);
        check("s1_bist_end_fin", bif.bist_end, 1);
        check("s1_latency", f1 - c0, 28);
        tick();
        tick();
        check("s1_init_cnt", n_init, 1);
        check("s1_run_cnt", n_run, 24);
        check("s1_tog_cnt", n_tog, 3);
        check("s1_fin_cnt", n_fin, 1);
        check("s1_bist_end", bif.bist_end, 1);
        check("s1_round", bif.round, 2);
        check("s1_aborted", bif.aborted, 0);
        check("s1_idle_running", bif.running, 0);

        // Start re-pulsed during RUN is ignored
        clr();
        launch(c0);
        tick();
        tick();
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        wait_fin(1'b0, 100, f1);
        check("s2_latency", f1 - c0, 28);
        tick();
        check("s2_run_cnt", n_run, 24);
        check("s2_tog_cnt", n_tog, 3);
        check("s2_init_cnt", n_init, 1);
        clr();
        bif.start = 1'b1;
        tick();
        check("s2b_init", bif.init, 1);
        check("s2b_bist_end_clr", bif.bist_end, 0);
        tick();
        bif.start = 1'b0;
        wait_fin(1'b0, 100, f1);
        tick();
        check("s2b_run_cnt", n_run, 24);

        // Start held through reset release is not an edge
        reset     = 1'b1;
        bif.start = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clr();
        tick();
        tick();
        tick();
        check("s3_no_init", n_init, 0);
        check("s3_flags", {bif.init, bif.running, bif.bist_end}, 0);
        bif.start = 1'b0;
        tick();
        clr();
        launch(c0);
        wait_fin(1'b0, 100, f1);
        check("s3_latency", f1 - c0, 28);
        tick();
        check("s3_run_cnt", n_run, 24);
        check("s3_tog_cnt", n_tog, 3);

        // Abort in round 1, cycle 4
        tick();
        clr();
        launch(c0);
        repeat (13) tick();
        check("s4_pre_round", bif.round, 1);
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        check("s4_running", bif.running, 0);
        check("s4_aborted", bif.aborted, 1);
        check("s4_bist_end", bif.bist_end, 0);
        check("s4_round", bif.round, 1);
        check("s4_tog_cnt", n_tog, 1);
        repeat (5) tick();
        check("s4_fin_cnt", n_fin, 0);
        check("s4_run_cnt", n_run, 13);
        check("s4_idle", {bif.init, bif.running}, 0);

        // Reset mid-RUN
        clr();
        launch(c0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("s5_rst_flags", {bif.init, bif.running, bif.toggle, bif.finish, bif.bist_end,
                               bif.aborted}, 0);
        check("s5_rst_round", bif.round, 0);
        reset = 1'b0;
        tick();
        clr();
        launch(c0);
        wait_fin(1'b0, 100, f1);
        check("s5_latency", f1 - c0, 28);
        tick();
        check("s5_run_cnt", n_run, 24);
        check("s5_tog_cnt", n_tog, 3);

        // Free-running: INIT + 2*(4+1) + FINISH = 12-cycle period
        cif.start = 1'b1;
        tick();
        c0 = cyc;
        check("s6_init", cif.init, 1);
        cif.start = 1'b0;
        wait_fin(1'b1, 50, f1);
        check("s6_latency", f1 - c0, 11);
        check("s6_bist_end_1", cif.bist_end, 1);
        tick();
        check("s6_bist_end_pulse", cif.bist_end, 0);
        check("s6_restart_init", cif.init, 1);
        check("s6_round_restart", cif.round, 0);
        wait_fin(1'b1, 50, f2);
        check("s6_period", f2 - f1, 12);
        check("s6_bist_end_2", cif.bist_end, 1);
        tick();
        cif.abort = 1'b1;
        tick();
        cif.abort = 1'b0;
        check("s6_aborted", cif.aborted, 1);
        check("s6_idle", {cif.init, cif.running, cif.bist_end}, 0);
        repeat (3) tick();
        check("s6_stays_idle", {cif.init, cif.running}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
